// File: rtl/suma_productos_pkg.sv
// Shared definitions for the SumaProductos response analyser:
// state encoding, default golden truth table and the table lookup helper.
package suma_productos_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  // F = A&B | C&D with A as the stimulus MSB; bit i is F(estimulo == i).
  localparam logic [15:0] TABLA_DEF = 16'hF888;

  // Golden response for one stimulus. The table is passed zero-extended so
  // the helper serves any stimulus width up to 8 bits.
  function automatic logic esperado(input logic [255:0] tabla, input logic [7:0] idx);
    return tabla[idx];
  endfunction

endpackage

// File: rtl/suma_productos_contador_errores.sv
// Saturating mismatch counter for one implementation under test.
// clr has priority over inc; the count sticks at all-ones instead of wrapping.
module suma_productos_contador_errores
  import suma_productos_pkg::*;
#(
  parameter int CNT_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             inc,
  output logic [CNT_W-1:0] cuenta
);

  logic [CNT_W-1:0] cuenta_q, cuenta_d;

  // Next count: clear, or increment unless already saturated.
  always_comb begin
    cuenta_d = cuenta_q;
    if (clr) begin
      cuenta_d = '0;
    end else if (inc && (cuenta_q != '1)) begin
      cuenta_d = cuenta_q + 1'b1;
    end
  end

  // Count register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) cuenta_q <= '0;
    else     cuenta_q <= cuenta_d;
  end

  assign cuenta = cuenta_q;

endmodule

// File: rtl/suma_productos_verificador.sv
// Response analyser for the SumaProductos implementations.
// A two-stage pipe samples {estimulo, respuestas} in RUN and compares each
// response bit to the golden table one cycle later, feeding per-implementation
// saturating counters and a coverage map. The run ends when every stimulus has
// been seen (coverage wins ties) or when the RUN timer hits TIMEOUT.
// Handshake: a sample is taken on any rising edge where estimulo_valido=1 and
// the FSM is in RUN; there is no ready, samples outside RUN are dropped.
module suma_productos_verificador
  import suma_productos_pkg::*;
#(
  parameter int                     N_ENT   = 4,
  parameter int                     N_IMPL  = 4,
  parameter logic [(1<<N_ENT)-1:0]  TABLA   = TABLA_DEF,
  parameter int                     CNT_W   = 5,
  parameter int                     TIMEOUT = 64
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    inicio,
  input  logic                    estimulo_valido,
  input  logic [N_ENT-1:0]        estimulo,
  input  logic [N_IMPL-1:0]       respuestas,
  output logic                    ocupado,
  output logic                    listo,
  output logic                    pasa,
  output logic                    agotado,
  output logic [N_IMPL*CNT_W-1:0] errores,
  output logic [(1<<N_ENT)-1:0]   cobertura,
  output logic [1:0]              estado
);

  localparam int NCOMB = 1 << N_ENT;
  localparam int TW    = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [TW-1:0] TMAX = TW'(TIMEOUT);

  logic [1:0]        estado_q, estado_d;
  logic              s1_valid_q;
  logic [N_ENT-1:0]  s1_est_q;
  logic [N_IMPL-1:0] s1_resp_q;
  logic [NCOMB-1:0]  cob_q, cob_d;
  logic [TW-1:0]     timer_q, timer_d;
  logic              agot_q, agot_d;
  logic              pasa_q, pasa_d;
  logic              arranque, en_run, commit, cob_full_d, tout_d, errs_zero, exp_bit;
  logic [N_IMPL-1:0] mismatch;
  logic [CNT_W-1:0]  cuentas [N_IMPL];

  // A start is honoured only from IDLE or DONE; it clears everything.
  assign arranque   = inicio && ((estado_q == ST_IDLE) || (estado_q == ST_DONE));
  assign en_run     = (estado_q == ST_RUN);
  // Stage 2 commits in RUN and in DRAIN so the last captured sample counts.
  assign commit     = s1_valid_q && ((estado_q == ST_RUN) || (estado_q == ST_DRAIN));
  assign exp_bit    = esperado(256'(TABLA), 8'(s1_est_q));
  assign mismatch   = s1_resp_q ^ {N_IMPL{exp_bit}};
  assign cob_full_d = &cob_d;
  assign tout_d     = (TIMEOUT != 0) && (timer_d == TMAX);

  // State register.
  always_ff @(posedge clk) begin
    if (rst) estado_q <= ST_IDLE;
    else     estado_q <= estado_d;
  end

  // Next-state logic; end-of-run conditions look at the values being written
  // this edge so the FSM leaves RUN on the same edge coverage fills.
  always_comb begin
    estado_d = estado_q;
    case (estado_q)
      ST_IDLE:  if (inicio) estado_d = ST_RUN;
      ST_RUN:   if (cob_full_d || tout_d) estado_d = ST_DRAIN;
      ST_DRAIN: estado_d = ST_DONE;
      ST_DONE:  if (inicio) estado_d = ST_RUN;
      default:  estado_d = ST_IDLE;
    endcase
  end

  // Status outputs decoded from the state.
  always_comb begin
    ocupado = (estado_q == ST_RUN) || (estado_q == ST_DRAIN);
    listo   = (estado_q == ST_DONE);
  end

  // Stage 1: capture the sample presented in RUN.
  always_ff @(posedge clk) begin
    if (rst || arranque) begin
      s1_valid_q <= 1'b0;
      s1_est_q   <= '0;
      s1_resp_q  <= '0;
    end else begin
      s1_valid_q <= en_run && estimulo_valido;
      if (en_run && estimulo_valido) begin
        s1_est_q  <= estimulo;
        s1_resp_q <= respuestas;
      end
    end
  end

  // All counters currently zero.
  always_comb begin
    errs_zero = 1'b1;
    for (int k = 0; k < N_IMPL; k++) begin
      if (cuentas[k] != '0) errs_zero = 1'b0;
    end
  end

  // Coverage, timer and verdict next values.
  always_comb begin
    cob_d   = cob_q;
    timer_d = timer_q;
    agot_d  = agot_q;
    pasa_d  = pasa_q;
    if (arranque) begin
      cob_d   = '0;
      timer_d = '0;
      agot_d  = 1'b0;
      pasa_d  = 1'b0;
    end else begin
      if (commit) cob_d[s1_est_q] = 1'b1;
      if (en_run && (TIMEOUT != 0) && (timer_q != TMAX)) timer_d = timer_q + 1'b1;
      // Coverage completing on the same edge suppresses the timeout flag.
      if (en_run && tout_d && !cob_full_d) agot_d = 1'b1;
      // Verdict uses the post-DRAIN values, including the final commit.
      if (estado_q == ST_DRAIN)
        pasa_d = cob_full_d && !agot_q && errs_zero && !(commit && (|mismatch));
    end
  end

  // Coverage, timer and verdict registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      cob_q   <= '0;
      timer_q <= '0;
      agot_q  <= 1'b0;
      pasa_q  <= 1'b0;
    end else begin
      cob_q   <= cob_d;
      timer_q <= timer_d;
      agot_q  <= agot_d;
      pasa_q  <= pasa_d;
    end
  end

  genvar g;
  generate
    for (g = 0; g < N_IMPL; g++) begin : g_cnt
      suma_productos_contador_errores #(.CNT_W(CNT_W)) u_cnt (
        .clk    (clk),
        .rst    (rst),
        .clr    (arranque),
        .inc    (commit && mismatch[g]),
        .cuenta (cuentas[g])
      );
      assign errores[g*CNT_W +: CNT_W] = cuentas[g];
    end
  endgenerate

  assign pasa      = pasa_q;
  assign agotado   = agot_q;
  assign cobertura = cob_q;
  assign estado    = estado_q;

endmodule

// File: tb/tb_suma_productos_verificador.sv
// Directed bench for suma_productos_verificador. Each accepted sample pushes
// its expected index/mismatch pair; it is popped on the commit edge and the
// running error totals and coverage are compared against the DUT.
module tb_suma_productos_verificador;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        inicio = 1'b0;
  logic        estimulo_valido = 1'b0;
  logic [3:0]  estimulo = '0;
  logic [3:0]  respuestas = '0;
  logic        ocupado, listo, pasa, agotado;
  logic [19:0] errores;
  logic [15:0] cobertura;
  logic [1:0]  estado;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int c0    = 0;

  logic [7:0]  exp_q[$];
  int          m_err [4];
  logic [15:0] m_cov;

  suma_productos_verificador dut (
    .clk             (clk),
    .rst             (rst),
    .inicio          (inicio),
    .estimulo_valido (estimulo_valido),
    .estimulo        (estimulo),
    .respuestas      (respuestas),
    .ocupado         (ocupado),
    .listo           (listo),
    .pasa            (pasa),
    .agotado         (agotado),
    .errores         (errores),
    .cobertura       (cobertura),
    .estado          (estado)
  );

  // Clock.
  always #5 clk = ~clk;

  // Reference function F = A&B | C&D, A = estimulo[3].
  function automatic logic f_ref(input logic [3:0] i);
    return (i[3] & i[2]) | (i[1] & i[0]);
  endfunction

  function automatic logic [19:0] pack_err();
    logic [19:0] p;
    for (int k = 0; k < 4; k++) p[k*5 +: 5] = 5'(m_err[k]);
    return p;
  endfunction

  task automatic clr_model();
    for (int k = 0; k < 4; k++) m_err[k] = 0;
    m_cov = '0;
    exp_q.delete();
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // One clock: drive, edge, then retire the sample committed on this edge.
  task automatic step(input logic v, input logic [3:0] e, input logic [3:0] r, input bit cap);
    logic [7:0] ent;
    estimulo_valido = v;
    estimulo = e;
    respuestas = r;
    @(posedge clk);
    #1;
    cyc++;
    if (exp_q.size() > 0) begin
      ent = exp_q.pop_front();
      for (int k = 0; k < 4; k++)
        if (ent[k] && m_err[k] < 31) m_err[k]++;
      m_cov[ent[7:4]] = 1'b1;
      chk("commit_errores", 64'(errores), 64'(pack_err()));
      chk("commit_cobertura", 64'(cobertura), 64'(m_cov));
    end
    if (v && cap) exp_q.push_back({e, r ^ {4{f_ref(e)}}});
    estimulo_valido = 1'b0;
  endtask

  task automatic start();
    inicio = 1'b1;
    step(1'b0, 4'd0, 4'd0, 1'b0);
    inicio = 1'b0;
    clr_model();
    c0 = cyc;
  endtask

  task automatic wait_listo(input string tag, input int lat);
    int n;
    n = 0;
    while (listo !== 1'b1 && n < 200) begin
      step(1'b0, 4'd0, 4'd0, 1'b0);
      n++;
    end
    chk(tag, 64'(cyc - c0), 64'(lat));
  endtask

  task automatic sweep(input logic [3:0] lo, input logic [3:0] hi, input logic [3:0] flip_idx_a,
                       input logic [3:0] flip_idx_b, input logic [3:0] flip_mask);
    for (int i = int'(lo); i <= int'(hi); i++) begin
      logic [3:0] r;
      r = {4{f_ref(4'(i))}};
      if (4'(i) == flip_idx_a || 4'(i) == flip_idx_b) r = r ^ flip_mask;
      step(1'b1, 4'(i), r, 1'b1);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    estimulo_valido = 1'b0;
    inicio = 1'b0;
    @(posedge clk);
    #1;
    cyc++;
    rst = 1'b0;
    clr_model();
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_outs"}, 64'({ocupado, listo, pasa, agotado, estado}), 64'd0);
    chk({tag, "_errores"}, 64'(errores), 64'd0);
    chk({tag, "_cobertura"}, 64'(cobertura), 64'd0);
  endtask

  initial begin
    clr_model();
    // Reset state.
    @(posedge clk); #1;
    do_reset();
    chk_all_zero("reset");

    // Samples in IDLE are dropped.
    for (int i = 0; i < 3; i++) step(1'b1, 4'(i + 5), 4'hF, 1'b0);
    chk_all_zero("idle_samples");

    // 1. Golden sweep.
    start();
    chk("t1_ocupado", 64'(ocupado), 64'd1);
    sweep(4'd0, 4'd15, 4'd0, 4'd0, 4'h0);
    wait_listo("t1_latency", 18);
    chk("t1_pasa", 64'(pasa), 64'd1);
    chk("t1_agotado", 64'(agotado), 64'd0);
    chk("t1_errores", 64'(errores), 64'd0);
    chk("t1_cobertura", 64'(cobertura), 64'hFFFF);
    chk("t1_ocupado_done", 64'(ocupado), 64'd0);

    // 2. Implementation 2 wrong at 3 and 12.
    start();
    sweep(4'd0, 4'd15, 4'd3, 4'd12, 4'b0100);
    wait_listo("t2_latency", 18);
    chk("t2_errores", 64'(errores), 64'h00800);
    chk("t2_pasa", 64'(pasa), 64'd0);
    chk("t2_agotado", 64'(agotado), 64'd0);

    // 3. Saturation.
    start();
    for (int n = 0; n < 40; n++) step(1'b1, 4'd0, 4'hF, 1'b1);
    sweep(4'd1, 4'd15, 4'd0, 4'd0, 4'h0);
    wait_listo("t3_latency", 57);
    chk("t3_errores", 64'(errores), 64'hFFFFF);
    chk("t3_pasa", 64'(pasa), 64'd0);

    // 4. Timeout with half coverage.
    start();
    sweep(4'd0, 4'd7, 4'd0, 4'd0, 4'h0);
    wait_listo("t4_latency", 65);
    chk("t4_agotado", 64'(agotado), 64'd1);
    chk("t4_cobertura", 64'(cobertura), 64'h00FF);
    chk("t4_pasa", 64'(pasa), 64'd0);
    chk("t4_errores", 64'(errores), 64'd0);

    // 5. Reset mid-run, then a clean sweep.
    start();
    sweep(4'd0, 4'd4, 4'd0, 4'd0, 4'h0);
    do_reset();
    chk_all_zero("t5_reset");
    start();
    sweep(4'd0, 4'd15, 4'd0, 4'd0, 4'h0);
    wait_listo("t5_latency", 18);
    chk("t5_pasa", 64'(pasa), 64'd1);

    // 6. Samples in DONE ignored; inicio in DONE restarts; inicio in RUN ignored.
    for (int i = 0; i < 3; i++) step(1'b1, 4'(i), ~{4{f_ref(4'(i))}}, 1'b0);
    chk("t6_done_errores", 64'(errores), 64'd0);
    chk("t6_done_cobertura", 64'(cobertura), 64'hFFFF);
    chk("t6_done_hold", 64'({listo, pasa}), 64'b11);
    start();
    chk("t6_restart_cobertura", 64'(cobertura), 64'd0);
    chk("t6_restart_listo", 64'({ocupado, listo, pasa}), 64'b100);
    sweep(4'd0, 4'd3, 4'd0, 4'd0, 4'h0);
    inicio = 1'b1;
    step(1'b1, 4'd4, {4{f_ref(4'd4)}}, 1'b1);
    inicio = 1'b0;
    sweep(4'd5, 4'd15, 4'd9, 4'd9, 4'b0001);
    wait_listo("t6_latency", 18);
    chk("t6_errores", 64'(errores), 64'h00001);
    chk("t6_pasa", 64'(pasa), 64'd0);
    chk("t6_cobertura", 64'(cobertura), 64'hFFFF);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
